// File: rtl/sysio_axil_master_if.sv
// AXI4-Lite AW/W/AR/R bundle between the sysio bridge and the peripheral bus.
// The B channel is absent; writes complete on the AW+W handshakes.
interface sysio_axil_master_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0]   awaddr;
    logic            awvalid;
    logic            awready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wvalid;
    logic            wready;
    logic [AW-1:0]   araddr;
    logic            arvalid;
    logic            arready;
    logic [DW-1:0]   rdata;
    logic            rvalid;
    logic            rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid,
        output araddr, arvalid, rready,
        input  awready, wready, arready, rdata, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid,
        input  araddr, arvalid, rready,
        output awready, wready, arready, rdata, rvalid
    );
endinterface

// File: rtl/sysio_axil_master.sv
// Single-outstanding core command/response to AXI4-Lite initiator bridge.
// SYSIO_AXIL_MST_TIMEOUT_EN adds a TO_CYC hang-abort counter.
module sysio_axil_master #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int TO_CYC = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_we,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    input  logic [3:0]    cmd_sel,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    sysio_axil_master_if.master m_axi
);
    typedef enum logic [2:0] {
        IDLE, WR, RD_A, RD_D, RESP
    } state_e;

    localparam logic [7:0] TO_LIM = TO_CYC[7:0];

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [3:0]    sel_q, sel_d;
    logic          awvalid_q, awvalid_d;
    logic          wvalid_q, wvalid_d;
    logic          arvalid_q, arvalid_d;
    logic          rready_q, rready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_err_q, rsp_err_d;
    logic [DW-1:0] rdata_q, rdata_d;

`ifdef SYSIO_AXIL_MST_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       progress;
`else
    logic       unused_to;
    assign unused_to = ^TO_LIM;
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        sel_d       = sel_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rdata_d     = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    sel_d   = cmd_sel;
                    if (cmd_we) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = RD_A;
                    end
                end
            end
            WR: begin
                // AW and W retire independently; done once both valids are low
                if (m_axi.awready) awvalid_d = 1'b0;
                if (m_axi.wready) wvalid_d = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rdata_d     = '0;
                    state_d     = RESP;
                end
            end
            RD_A: begin
                if (m_axi.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_D;
                end
            end
            RD_D: begin
                if (m_axi.rvalid) begin
                    rready_d    = 1'b0;
                    rdata_d     = m_axi.rdata;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef SYSIO_AXIL_MST_TIMEOUT_EN
        progress = (awvalid_q && m_axi.awready)
                 || (wvalid_q && m_axi.wready)
                 || (arvalid_q && m_axi.arready)
                 || (rready_q && m_axi.rvalid);
        cnt_d = '0;
        if (state_q inside {WR, RD_A, RD_D}) begin
            cnt_d = progress ? 8'd0 : cnt_q + 8'd1;
            if (!progress && cnt_q == TO_LIM) begin
                awvalid_d   = 1'b0;
                wvalid_d    = 1'b0;
                arvalid_d   = 1'b0;
                rready_d    = 1'b0;
                rdata_d     = 32'hDEAD_BEEF;
                rsp_err_d   = 1'b1;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            sel_q       <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rdata_q     <= '0;
`ifdef SYSIO_AXIL_MST_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            sel_q       <= sel_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rdata_q     <= rdata_d;
`ifdef SYSIO_AXIL_MST_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign cmd_ready     = (state_q == IDLE);
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rdata_q;
    assign rsp_err       = rsp_err_q;
    assign m_axi.awaddr  = addr_q;
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = sel_q;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.araddr  = addr_q;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.rready  = rready_q;
endmodule

// File: tb/tb_sysio_axil_master.sv
// Bench for sysio_axil_master: delay-programmable AXI-Lite slave, transaction model
// checked every cycle at negedge, plus directed literal checks per scenario.
module tb_sysio_axil_master;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_sel = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    always #5 clk = ~clk;

    sysio_axil_master_if #(.AW(32), .DW(32)) axi ();

    sysio_axil_master #(.AW(32), .DW(32), .TO_CYC(TO)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_sel   (cmd_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .m_axi     (axi.master)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // slave configuration
    int          aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 0;
    logic [31:0] r_word = '0;
    logic        exp_abort = 1'b0;

    // model of the single outstanding access
    logic        busy = 1'b0;
    logic        c_we, c_err, c_aw, c_w, c_ar, c_r;
    logic [31:0] c_addr, c_wdata, c_rdata;
    logic [3:0]  c_sel;
    int          n_rsp = 0;

    int   aw_c, w_c, ar_c, r_c;
    logic r_go, hs_ar_p, hs_r_p;
    logic hs_aw, hs_w, hs_ar, hs_r;
    logic p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_rsv, p_rsr;
    logic [31:0] p_awaddr, p_wdata, p_araddr, p_rsd;

    initial begin
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.rdata   = 32'h0BAD_0BAD;
        {aw_c, w_c, ar_c, r_c} = '0;
        {r_go, hs_ar_p, hs_r_p} = '0;
        {p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_rsv, p_rsr} = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_valids",
                      {axi.awvalid, axi.wvalid, axi.arvalid, axi.rready, rsp_valid, rsp_err}, '0);
                busy = 1'b0;
                axi.awready = 1'b0;
                axi.wready  = 1'b0;
                axi.arready = 1'b0;
                axi.rvalid  = 1'b0;
                {aw_c, w_c, ar_c, r_c} = '0;
                {r_go, hs_ar_p, hs_r_p} = '0;
                {p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_rsv, p_rsr} = '0;
                continue;
            end
            check("cmd_ready", cmd_ready, !busy);
            if (!exp_abort) begin
                if (p_awv && !p_awr) begin
                    check("aw_hold", axi.awvalid, 1);
                    check("aw_addr_stable", axi.awaddr, p_awaddr);
                end
                if (p_wv && !p_wr) begin
                    check("w_hold", axi.wvalid, 1);
                    check("w_data_stable", axi.wdata, p_wdata);
                end
                if (p_arv && !p_arr) begin
                    check("ar_hold", axi.arvalid, 1);
                    check("ar_addr_stable", axi.araddr, p_araddr);
                end
                if (busy && c_ar && !c_r) begin
                    check("rd_d_rready", axi.rready, 1);
                    check("rd_d_arvalid", axi.arvalid, 0);
                end
            end
            if (p_rsv && !p_rsr) begin
                check("rsp_hold", rsp_valid, 1);
                check("rsp_data_stable", rsp_rdata, p_rsd);
            end

            // slave reacts to what the DUT presents now
            if (hs_r_p) begin
                axi.rvalid = 1'b0;
                axi.rdata  = ~r_word;
                r_go = 1'b0;
            end
            if (hs_ar_p) begin
                r_go = 1'b1;
                r_c  = 0;
            end
            axi.awready = axi.awvalid && (aw_c >= aw_dly);
            aw_c = axi.awvalid ? aw_c + 1 : 0;
            axi.wready = axi.wvalid && (w_c >= w_dly);
            w_c = axi.wvalid ? w_c + 1 : 0;
            axi.arready = axi.arvalid && (ar_c >= ar_dly);
            ar_c = axi.arvalid ? ar_c + 1 : 0;
            if (r_go && !axi.rvalid) begin
                if (r_c >= r_dly) begin
                    axi.rvalid = 1'b1;
                    axi.rdata  = r_word;
                end else begin
                    r_c++;
                end
            end

            // handshakes that will occur on the coming posedge
            hs_aw = axi.awvalid && axi.awready;
            hs_w  = axi.wvalid && axi.wready;
            hs_ar = axi.arvalid && axi.arready;
            hs_r  = axi.rvalid && axi.rready;
            if (hs_aw) begin
                check("aw_once", {busy, c_we, c_aw}, 3'b110);
                check("awaddr", axi.awaddr, c_addr);
                c_aw = 1'b1;
            end
            if (hs_w) begin
                check("w_once", {busy, c_we, c_w}, 3'b110);
                check("wdata", axi.wdata, c_wdata);
                check("wstrb", axi.wstrb, c_sel);
                c_w = 1'b1;
            end
            if (hs_ar) begin
                check("ar_once", {busy, c_we, c_ar}, 3'b100);
                check("araddr", axi.araddr, c_addr);
                c_ar = 1'b1;
            end
            if (hs_r) begin
                check("r_after_ar", {busy, c_ar, c_r}, 3'b110);
                c_r = 1'b1;
            end
            if (rsp_valid) begin
                check("rsp_busy", busy, 1);
                if (!c_err) check("rsp_after_bus", c_we ? (c_aw && c_w) : c_r, 1);
                check("rsp_rdata", rsp_rdata, c_rdata);
                check("rsp_err", rsp_err, c_err);
                if (rsp_ready) begin
                    busy = 1'b0;
                    n_rsp++;
                end
            end
            if (cmd_valid && cmd_ready) begin
                busy    = 1'b1;
                c_we    = cmd_we;
                c_addr  = cmd_addr;
                c_wdata = cmd_wdata;
                c_sel   = cmd_sel;
                c_err   = exp_abort;
                c_rdata = cmd_we ? 32'h0 : (exp_abort ? 32'hDEAD_BEEF : r_word);
                {c_aw, c_w, c_ar, c_r} = '0;
            end
            hs_ar_p = hs_ar;
            hs_r_p  = hs_r;
            p_awv = axi.awvalid; p_awr = axi.awready; p_awaddr = axi.awaddr;
            p_wv  = axi.wvalid;  p_wr  = axi.wready;  p_wdata  = axi.wdata;
            p_arv = axi.arvalid; p_arr = axi.arready; p_araddr = axi.araddr;
            p_rsv = rsp_valid;   p_rsr = rsp_ready;   p_rsd    = rsp_rdata;
        end
    end

    task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output int n);
        logic rdy;
        cmd_we    = we;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_sel   = s;
        cmd_valid = 1'b1;
        n = 0;
        do begin
            rdy = cmd_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 200);
        cmd_valid = 1'b0;
        check("cmd_accept", rdy, 1);
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("rsp_seen", rsp_valid, 1);
    endtask

    task automatic rsp_done();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    int n, m, saved;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("reset_cmd_ready", cmd_ready, 1);
        check("reset_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
        check("reset_bus", {axi.awvalid, axi.wvalid, axi.arvalid, axi.rready}, 0);
        check("reset_addr", axi.awaddr, 0);

        // zero-wait read, then back-to-back read
        r_word = 32'h1234_5678;
        issue(1'b0, 32'h0000_0104, 32'h0, 4'h0, n);
        check("t1_arvalid", axi.arvalid, 1);
        check("t1_araddr", axi.araddr, 32'h0000_0104);
        wait_rsp(n);
        check("t1_lat", n, 2);
        check("t1_rdata", rsp_rdata, 32'h1234_5678);
        check("t1_err", rsp_err, 0);
        r_word = 32'h5566_7788;
        issue(1'b0, 32'h0000_0108, 32'h0, 4'h0, m);
        check("t1_b2b_read", m, 2);
        wait_rsp(n);
        check("t1b_rdata", rsp_rdata, 32'h5566_7788);
        rsp_done();

        // zero-wait write
        issue(1'b1, 32'h0000_0010, 32'hCAFE_F00D, 4'hF, n);
        wait_rsp(n);
        check("wr_lat", n, 1);
        check("wr_rdata", rsp_rdata, 0);
        rsp_done();

        // write with awready two cycles ahead of wready
        aw_dly = 1;
        w_dly  = 3;
        issue(1'b1, 32'h0000_0200, 32'hA5A5_0F0F, 4'b0011, n);
        check("t2_both_valid", {axi.awvalid, axi.wvalid}, 2'b11);
        check("t2_wstrb", axi.wstrb, 4'b0011);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("t2_skew", {axi.awvalid, axi.wvalid}, 2'b01);
        wait_rsp(n);
        check("t2_lat", n, 1);
        check("t2_rdata", rsp_rdata, 0);
        rsp_done();
        aw_dly = 0;
        w_dly  = 0;

        // response backpressure with a queued second command
        rsp_ready = 1'b0;
        issue(1'b1, 32'h0000_0300, 32'h1122_3344, 4'hF, n);
        wait_rsp(n);
        r_word    = 32'hFEED_C0DE;
        cmd_we    = 1'b0;
        cmd_addr  = 32'h0000_0304;
        cmd_valid = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            check("t3_cmd_blocked", cmd_ready, 0);
            check("t3_rsp_held", {rsp_valid, rsp_rdata}, {1'b1, 32'h0});
        end
        rsp_ready = 1'b1;
        issue(1'b0, 32'h0000_0304, 32'h0, 4'h0, m);
        check("t3_accept_delay", m, 2);
        wait_rsp(n);
        check("t3_rdata", rsp_rdata, 32'hFEED_C0DE);
        rsp_done();

        // rvalid stalled ten cycles
        r_dly  = 10;
        r_word = 32'h0BAD_F00D;
        issue(1'b0, 32'h0000_0108, 32'h0, 4'h0, n);
        wait_rsp(n);
        check("t4_lat", n, 12);
        check("t4_rdata", rsp_rdata, 32'h0BAD_F00D);
        rsp_done();
        r_dly = 0;

        // asynchronous reset in the middle of a write
        aw_dly = 1000;
        w_dly  = 1000;
        saved  = n_rsp;
        issue(1'b1, 32'h0000_0400, 32'hDEAD_0001, 4'hF, n);
        @(posedge clk);
        #1;
        check("t5_awvalid_pre", axi.awvalid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_clear", {axi.awvalid, axi.wvalid, axi.arvalid, rsp_valid}, 0);
        aw_dly = 0;
        w_dly  = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("t5_idle", cmd_ready, 1);
        check("t5_no_rsp", n_rsp, saved);
        r_word = 32'h1234_5678;
        issue(1'b0, 32'h0000_0104, 32'h0, 4'h0, n);
        wait_rsp(n);
        check("t5_read_lat", n, 2);
        check("t5_read_data", rsp_rdata, 32'h1234_5678);
        rsp_done();

        // slave never raises arready
        ar_dly = 1000;
`ifdef SYSIO_AXIL_MST_TIMEOUT_EN
        exp_abort = 1'b1;
        issue(1'b0, 32'h0000_0500, 32'h0, 4'h0, n);
        wait_rsp(n);
        check("t6_to_lat", (n >= TO && n <= TO + 1), 1);
        check("t6_arvalid", axi.arvalid, 0);
        check("t6_err", rsp_err, 1);
        check("t6_rdata", rsp_rdata, 32'hDEAD_BEEF);
        rsp_done();
        exp_abort = 1'b0;
        ar_dly = 0;
`else
        issue(1'b0, 32'h0000_0500, 32'h0, 4'h0, n);
        repeat (100) begin
            @(posedge clk);
            #1;
        end
        check("t6_still_waiting", {axi.arvalid, rsp_valid, rsp_err}, 3'b100);
        ar_dly = 0;
        do_reset();
`endif
        r_word = 32'h7777_0001;
        issue(1'b0, 32'h0000_0600, 32'h0, 4'h0, n);
        wait_rsp(n);
        check("final_rdata", rsp_rdata, 32'h7777_0001);
        rsp_done();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
